vx_barrier_ctrl: RTL and testbench

- Central barrier controller for one core. It owns the per-barrier arrival state that the warp scheduler consults.
- Accepts barrier-arrive requests from the warp-control path. Tracks which warps wait on each barrier and exports a per-warp stall mask to the scheduler.
- Issues a registered release (warp mask) once the expected number of warps has arrived.
- Also services warp-kill events, which purge a deactivated warp from every barrier.

---
 rtl/vx_barrier_pkg.sv | 48 ++++
 rtl/vx_barrier_slot.sv | 50 +++++
 rtl/vx_barrier_ctrl.sv | 114 +++++++++++
 tb/tb_vx_barrier_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_barrier_pkg.sv
// Shared types and helpers for the barrier controller.
// Optional feature macro used by the top level: VX_BARRIER_PERF_EN.
package vx_barrier_pkg;

  localparam int unsigned NUM_WARPS    = 4;
  localparam int unsigned NUM_BARRIERS = 4;

  // Warp id width: NUM_WARPS is a power of two and at least 2.
  function automatic int unsigned warp_id_bits(input int unsigned n);
    return $clog2(n);
  endfunction

  // Barrier id width: at least one bit even for a single barrier slot.
  function automatic int unsigned bar_id_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NW_BITS  = warp_id_bits(NUM_WARPS);
  localparam int unsigned NB_BITS  = bar_id_bits(NUM_BARRIERS);
  localparam int unsigned CNT_BITS = NW_BITS + 1;

  typedef struct packed {
    logic [NW_BITS-1:0] wid;
    logic [NB_BITS-1:0] bid;
    logic [NW_BITS-1:0] size_m1;
  } arrive_req_t;

  typedef struct packed {
    logic [NUM_WARPS-1:0] mask;
    logic [NB_BITS-1:0]   bid;
  } release_t;

  // Number of set bits in a warp mask.
  function automatic logic [CNT_BITS-1:0] popcount(input logic [NUM_WARPS-1:0] m);
    logic [CNT_BITS-1:0] c;
    c = '0;
    for (int i = 0; i < int'(NUM_WARPS); i++) begin
      c = c + CNT_BITS'(m[i]);
    end
    return c;
  endfunction

  // One-hot warp mask for a warp id.
  function automatic logic [NUM_WARPS-1:0] warp_bit(input logic [NW_BITS-1:0] w);
    return NUM_WARPS'(1) << w;
  endfunction

endpackage

// File: rtl/vx_barrier_slot.sv
// One barrier slot: wait mask, arrival count, reach check and kill purge.
module vx_barrier_slot
  import vx_barrier_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hit,
  input  logic [NW_BITS-1:0]   wid,
  input  logic [NW_BITS-1:0]   size_m1,
  input  logic                 kill_valid,
  input  logic [NW_BITS-1:0]   kill_wid,
  output logic [NUM_WARPS-1:0] wait_mask,
  output logic                 reach_c,
  output logic                 dup_c,
  output logic [NUM_WARPS-1:0] release_mask_c
);

  logic [NUM_WARPS-1:0] kill_bit;
  logic [NUM_WARPS-1:0] live;
  logic [NUM_WARPS-1:0] next_mask;
  logic [CNT_BITS-1:0]  count;
  logic                 eff;

  // Apply the kill first, then the arrival against the post-kill mask.
  always_comb begin
    kill_bit       = kill_valid ? warp_bit(kill_wid) : '0;
    live           = wait_mask & ~kill_bit;
    eff            = hit && !(kill_valid && (kill_wid == wid));
    count          = popcount(live);
    dup_c          = eff && wait_mask[wid];
    reach_c        = eff && !wait_mask[wid] && (count >= CNT_BITS'(size_m1));
    release_mask_c = live | warp_bit(wid);
    next_mask      = live;
    if (reach_c) begin
      next_mask = '0;
    end else if (eff && !dup_c) begin
      next_mask = live | warp_bit(wid);
    end
  end

  // Wait mask register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_mask <= '0;
    end else begin
      wait_mask <= next_mask;
    end
  end

endmodule

// File: rtl/vx_barrier_ctrl.sv
// Barrier controller: bid decode, release register and arrive handshake.
// Define VX_BARRIER_PERF_EN to build the stall-cycle performance counter.
module vx_barrier_ctrl
  import vx_barrier_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive_valid,
  output logic                 arrive_ready,
  input  logic [NW_BITS-1:0]   arrive_wid,
  input  logic [NB_BITS-1:0]   arrive_bid,
  input  logic [NW_BITS-1:0]   arrive_size_m1,
  input  logic                 kill_valid,
  input  logic [NW_BITS-1:0]   kill_wid,
  output logic                 release_valid,
  input  logic                 release_ready,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic [NB_BITS-1:0]   release_bid,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic                 dup_err,
  output logic [63:0]          perf_wait_cycles
);

  arrive_req_t          req;
  release_t             rel_q;
  logic                 fire;
  logic                 reach_any;
  logic                 dup_any;
  logic [NUM_WARPS-1:0] sel_mask;
  logic [NUM_WARPS-1:0] stall_c;

  logic [NUM_BARRIERS-1:0] slot_hit;
  logic [NUM_BARRIERS-1:0] slot_reach;
  logic [NUM_BARRIERS-1:0] slot_dup;
  logic [NUM_WARPS-1:0]    slot_wait [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    slot_rel  [NUM_BARRIERS];

  assign req          = '{wid: arrive_wid, bid: arrive_bid, size_m1: arrive_size_m1};
  assign arrive_ready = !release_valid || release_ready;
  assign fire         = arrive_valid && arrive_ready;

  for (genvar b = 0; b < int'(NUM_BARRIERS); b++) begin : g_slot
    assign slot_hit[b] = fire && (req.bid == NB_BITS'(b));
    vx_barrier_slot u_slot (
      .clk            (clk),
      .reset          (reset),
      .hit            (slot_hit[b]),
      .wid            (req.wid),
      .size_m1        (req.size_m1),
      .kill_valid     (kill_valid),
      .kill_wid       (kill_wid),
      .wait_mask      (slot_wait[b]),
      .reach_c        (slot_reach[b]),
      .dup_c          (slot_dup[b]),
      .release_mask_c (slot_rel[b])
    );
  end

  // Merge slot results; at most one slot is hit per cycle.
  always_comb begin
    reach_any = 1'b0;
    dup_any   = 1'b0;
    sel_mask  = '0;
    stall_c   = '0;
    for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
      stall_c = stall_c | slot_wait[b];
      dup_any = dup_any | slot_dup[b];
      if (slot_reach[b]) begin
        reach_any = 1'b1;
        sel_mask  = sel_mask | slot_rel[b];
      end
    end
  end

  assign stall_mask   = stall_c;
  assign release_mask = rel_q.mask;
  assign release_bid  = rel_q.bid;

  // Single outstanding release; a new one may load in the handshake cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      release_valid <= 1'b0;
      rel_q         <= '0;
      dup_err       <= 1'b0;
    end else begin
      dup_err <= dup_any;
      if (reach_any) begin
        release_valid <= 1'b1;
        rel_q         <= '{mask: sel_mask, bid: req.bid};
      end else if (release_ready) begin
        release_valid <= 1'b0;
        rel_q         <= '0;
      end
    end
  end

`ifdef VX_BARRIER_PERF_EN
  logic [63:0] perf_q;

  // Accumulate stalled warp-cycles; wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_q + 64'(popcount(stall_c));
    end
  end

  assign perf_wait_cycles = perf_q;
`else
  assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Self-checking bench for vx_barrier_ctrl: directed table plus random vs. model.
module tb_vx_barrier_ctrl;
  import vx_barrier_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 arrive_valid;
  logic                 arrive_ready;
  logic [NW_BITS-1:0]   arrive_wid;
  logic [NB_BITS-1:0]   arrive_bid;
  logic [NW_BITS-1:0]   arrive_size_m1;
  logic                 kill_valid;
  logic [NW_BITS-1:0]   kill_wid;
  logic                 release_valid;
  logic                 release_ready;
  logic [NUM_WARPS-1:0] release_mask;
  logic [NB_BITS-1:0]   release_bid;
  logic [NUM_WARPS-1:0] stall_mask;
  logic                 dup_err;
  logic [63:0]          perf_wait_cycles;

  always #5 clk = ~clk;

  vx_barrier_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .arrive_valid     (arrive_valid),
    .arrive_ready     (arrive_ready),
    .arrive_wid       (arrive_wid),
    .arrive_bid       (arrive_bid),
    .arrive_size_m1   (arrive_size_m1),
    .kill_valid       (kill_valid),
    .kill_wid         (kill_wid),
    .release_valid    (release_valid),
    .release_ready    (release_ready),
    .release_mask     (release_mask),
    .release_bid      (release_bid),
    .stall_mask       (stall_mask),
    .dup_err          (dup_err),
    .perf_wait_cycles (perf_wait_cycles)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a set of waiting warps per barrier plus one release slot.
  logic [NUM_WARPS-1:0] m_wait [NUM_BARRIERS];
  logic                 m_rv;
  logic [NUM_WARPS-1:0] m_mask;
  logic [NB_BITS-1:0]   m_bid;
  logic                 m_dup;
  logic [63:0]          m_perf;
  logic                 ready_seen;

  typedef struct {
    logic                 rst, av;
    logic [NW_BITS-1:0]   w;
    logic [NB_BITS-1:0]   b;
    logic [NW_BITS-1:0]   s;
    logic                 kv;
    logic [NW_BITS-1:0]   kw;
    logic                 rr;
    logic                 e_ready, e_rv;
    logic [NUM_WARPS-1:0] e_mask;
    logic [NB_BITS-1:0]   e_bid;
    logic [NUM_WARPS-1:0] e_stall;
    logic                 e_dup;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int av, int w, int b, int s, int kv, int kw, int rr,
                              int er, int erv, int emask, int ebid, int estall, int edup);
    vec_t v;
    v.rst = rst[0]; v.av = av[0]; v.w = NW_BITS'(w); v.b = NB_BITS'(b);
    v.s = NW_BITS'(s); v.kv = kv[0]; v.kw = NW_BITS'(kw); v.rr = rr[0];
    v.e_ready = er[0]; v.e_rv = erv[0]; v.e_mask = NUM_WARPS'(emask);
    v.e_bid = NB_BITS'(ebid); v.e_stall = NUM_WARPS'(estall); v.e_dup = edup[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_WARPS-1:0] m_stall();
    logic [NUM_WARPS-1:0] s;
    s = '0;
    for (int i = 0; i < int'(NUM_BARRIERS); i++) s = s | m_wait[i];
    return s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(NUM_BARRIERS); i++) m_wait[i] = '0;
    m_rv = 1'b0; m_mask = '0; m_bid = '0; m_dup = 1'b0; m_perf = '0;
  endtask

  // Advance the model by one clock using the rules in plain set arithmetic.
  task automatic m_step(input logic r, input logic av, input logic [NW_BITS-1:0] w,
                        input logic [NB_BITS-1:0] b, input logic [NW_BITS-1:0] s,
                        input logic kv, input logic [NW_BITS-1:0] kw, input logic rr);
    logic fire, new_rel;
    logic [NUM_WARPS-1:0] relm;
    int cnt;
    if (r) begin
      m_reset();
      return;
    end
    fire = av && (!m_rv || rr);
    m_perf = m_perf + 64'($countones(m_stall()));
    if (kv) for (int i = 0; i < int'(NUM_BARRIERS); i++) m_wait[i][kw] = 1'b0;
    new_rel = 1'b0; m_dup = 1'b0; relm = '0;
    if (fire && !(kv && kw == w)) begin
      cnt = $countones(m_wait[b]);
      if (m_wait[b][w]) m_dup = 1'b1;
      else if (cnt >= int'(s)) begin
        relm = m_wait[b];
        relm[w] = 1'b1;
        m_wait[b] = '0;
        new_rel = 1'b1;
      end else m_wait[b][w] = 1'b1;
    end
    if (new_rel) begin
      m_rv = 1'b1; m_mask = relm; m_bid = b;
    end else if (rr) begin
      m_rv = 1'b0; m_mask = '0; m_bid = '0;
    end
  endtask

  // Drive one cycle, check ready before the edge and all outputs after it.
  task automatic drive(input logic r, input logic av, input logic [NW_BITS-1:0] w,
                       input logic [NB_BITS-1:0] b, input logic [NW_BITS-1:0] s,
                       input logic kv, input logic [NW_BITS-1:0] kw, input logic rr);
    @(negedge clk);
    reset = r; arrive_valid = av; arrive_wid = w; arrive_bid = b; arrive_size_m1 = s;
    kill_valid = kv; kill_wid = kw; release_ready = rr;
    #1;
    ready_seen = arrive_ready;
    check("arrive_ready", 64'(arrive_ready), 64'(!m_rv || rr));
    @(posedge clk);
    m_step(r, av, w, b, s, kv, kw, rr);
    #1;
    check("release_valid", 64'(release_valid), 64'(m_rv));
    check("release_mask", 64'(release_mask), 64'(m_mask));
    check("release_bid", 64'(release_bid), 64'(m_bid));
    check("stall_mask", 64'(stall_mask), 64'(m_stall()));
    check("dup_err", 64'(dup_err), 64'(m_dup));
`ifdef VX_BARRIER_PERF_EN
    check("perf_wait_cycles", perf_wait_cycles, m_perf);
`else
    check("perf_wait_cycles", perf_wait_cycles, 64'd0);
`endif
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, rr);
  endtask

  initial begin
    m_reset();
    reset = 1'b1; arrive_valid = 1'b0; arrive_wid = '0; arrive_bid = '0;
    arrive_size_m1 = '0; kill_valid = 1'b0; kill_wid = '0; release_ready = 1'b1;

    //        rst av w b s kv kw rr | rdy rv mask  bid stall dup
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 1,0,'b0000,0,'b0000,0));
    tbl.push_back(mk(0,1,0,1,3,0,0,1, 1,0,'b0000,0,'b0001,0));
    tbl.push_back(mk(0,1,1,1,3,0,0,1, 1,0,'b0000,0,'b0011,0));
    tbl.push_back(mk(0,1,2,1,3,0,0,1, 1,0,'b0000,0,'b0111,0));
    tbl.push_back(mk(0,1,3,1,3,0,0,1, 1,1,'b1111,1,'b0000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,0,'b0000,0,'b0000,0));
    tbl.push_back(mk(0,1,2,0,0,0,0,1, 1,1,'b0100,0,'b0000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,0,'b0000,0,'b0000,0));
    tbl.push_back(mk(0,1,1,2,2,0,0,1, 1,0,'b0000,0,'b0010,0));
    tbl.push_back(mk(0,1,1,2,2,0,0,1, 1,0,'b0000,0,'b0010,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,0,'b0000,0,'b0010,0));
    tbl.push_back(mk(0,0,0,0,0,1,1,1, 1,0,'b0000,0,'b0000,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0, 1,1,'b0001,0,'b0000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,1,'b0001,0,'b0000,0));
    tbl.push_back(mk(0,1,3,2,1,0,0,0, 0,1,'b0001,0,'b0000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,1,'b0001,0,'b0000,0));
    tbl.push_back(mk(0,1,3,2,0,0,0,1, 1,1,'b1000,2,'b0000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,0,'b0000,0,'b0000,0));
    tbl.push_back(mk(0,1,0,3,2,0,0,1, 1,0,'b0000,0,'b0001,0));
    tbl.push_back(mk(0,1,1,3,2,0,0,1, 1,0,'b0000,0,'b0011,0));
    tbl.push_back(mk(0,1,2,3,2,1,1,1, 1,0,'b0000,0,'b0101,0));
    tbl.push_back(mk(0,1,1,3,2,0,0,1, 1,1,'b0111,3,'b0000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,0,'b0000,0,'b0000,0));
    tbl.push_back(mk(0,1,0,1,3,0,0,1, 1,0,'b0000,0,'b0001,0));
    tbl.push_back(mk(0,1,2,1,3,1,2,1, 1,0,'b0000,0,'b0001,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,1, 1,0,'b0000,0,'b0000,0));
    tbl.push_back(mk(0,1,1,0,3,0,0,1, 1,0,'b0000,0,'b0010,0));
    tbl.push_back(mk(0,1,2,2,3,0,0,1, 1,0,'b0000,0,'b0110,0));
    tbl.push_back(mk(0,1,3,3,0,0,0,0, 1,1,'b1000,3,'b0110,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,'b0000,0,'b0000,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0,'b0000,0,'b0000,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].w, tbl[i].b, tbl[i].s,
            tbl[i].kv, tbl[i].kw, tbl[i].rr);
      check($sformatf("tbl%0d_ready", i), 64'(ready_seen), 64'(tbl[i].e_ready));
      check($sformatf("tbl%0d_rv", i), 64'(release_valid), 64'(tbl[i].e_rv));
      check($sformatf("tbl%0d_mask", i), 64'(release_mask), 64'(tbl[i].e_mask));
      check($sformatf("tbl%0d_bid", i), 64'(release_bid), 64'(tbl[i].e_bid));
      check($sformatf("tbl%0d_stall", i), 64'(stall_mask), 64'(tbl[i].e_stall));
      check($sformatf("tbl%0d_dup", i), 64'(dup_err), 64'(tbl[i].e_dup));
    end

    // Three warps stalled for ten cycles on top of the ramp-up (0+1+2+30).
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, NW_BITS'(0), NB_BITS'(0), NW_BITS'(3), 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, NW_BITS'(1), NB_BITS'(0), NW_BITS'(3), 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, NW_BITS'(2), NB_BITS'(0), NW_BITS'(3), 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) idle(1'b1);
`ifdef VX_BARRIER_PERF_EN
    check("perf_30_cycles", perf_wait_cycles, 64'd33);
`else
    check("perf_tied_zero", perf_wait_cycles, 64'd0);
`endif
    check("perf_stall", 64'(stall_mask), 64'h7);
    // Reset mid-wait returns everything to reset values.
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    check("rst_stall", 64'(stall_mask), 64'd0);
    check("rst_perf", perf_wait_cycles, 64'd0);
    check("rst_ready", 64'(arrive_ready), 64'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 99) < 60),
            NW_BITS'($urandom_range(0, NUM_WARPS - 1)),
            NB_BITS'($urandom_range(0, NUM_BARRIERS - 1)),
            NW_BITS'($urandom_range(0, NUM_WARPS - 1)),
            ($urandom_range(0, 99) < 10),
            NW_BITS'($urandom_range(0, NUM_WARPS - 1)),
            ($urandom_range(0, 99) < 70));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
